// File: rtl/vel_pkg.sv
// Shared state encoding, beat-select constants, default Q-format values and
// the saturation helper used by the velocity dispatcher.
package vel_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_ARB    = 3'd2;
    localparam state_t ST_SEND_X = 3'd3;
    localparam state_t ST_SEND_Y = 3'd4;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    localparam int NUM_BOTS_DEF = 3;
    localparam int VEL_W_DEF    = 16;
    localparam int FRAC_W_DEF   = 11;
    localparam int DELAY_DEF    = 300;
    localparam int VEL_MAX_DEF  = 20480;

    function automatic logic signed [31:0] vel_sat(input logic signed [31:0] v,
                                                   input logic signed [31:0] lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after the pointer,
// wrapping to the lowest index; one-hot grant plus a valid flag.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic                 o_valid
);

    logic [N-1:0] w_hi;
    logic [N-1:0] w_src;
    logic         w_found;

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            w_hi[i] = i_req[i] && (i > int'(i_ptr));
        end
        // Requesters above the pointer win; otherwise wrap to the bottom.
        w_src   = (|w_hi) ? w_hi : i_req;
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_src[i] && !w_found) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_valid = |i_req;
    end

endmodule

// File: rtl/vel_dispatch.sv
// Snapshots per-bot velocities on write_check, waits a settle delay, then sends
// each pending bot a vx beat followed by a vy beat. Macro VEL_CLAMP_EN clamps snapshots.
module vel_dispatch
    import vel_pkg::*;
#(
    parameter int NUM_BOTS     = NUM_BOTS_DEF,
    parameter int VEL_W        = VEL_W_DEF,
    parameter int FRAC_W       = FRAC_W_DEF,
    parameter int DELAY_CYCLES = DELAY_DEF,
    parameter int VEL_MAX      = VEL_MAX_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_check,
    input  logic [NUM_BOTS*VEL_W-1:0]   vx_bin,
    input  logic [NUM_BOTS*VEL_W-1:0]   vy_bin,
    input  logic [NUM_BOTS-1:0]         bot_rdy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VEL_W-1:0]            out_data,
    output logic [$clog2(NUM_BOTS)-1:0] out_bot,
    output logic                        out_sel,
    output logic [NUM_BOTS-1:0]         upd_done,
    output logic                        busy,
    output logic [7:0]                  ovr_cnt
);
    // state   | meaning
    // IDLE    | nothing pending, waiting for write_check
    // WAIT    | settle countdown, reloaded by every write_check
    // ARB     | pick next ready pending bot (one cycle when a candidate exists)
    // SEND_X  | vx beat of latched bot on the output
    // SEND_Y  | vy beat; handshake clears pending and pulses upd_done

    localparam int BW = $clog2(NUM_BOTS);
    localparam int CW = $clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY_CYCLES - 1);

    if (NUM_BOTS < 2 || NUM_BOTS > 8 || DELAY_CYCLES < 1 || FRAC_W >= VEL_W
        || VEL_MAX >= (1 << (VEL_W - 1))) begin : g_bad_cfg
        $error("vel_dispatch: illegal parameter set");
    end

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_ptr;
    logic [BW-1:0]        r_bot;
    logic [NUM_BOTS-1:0]  r_pend;
    logic [NUM_BOTS-1:0]  r_done;
    logic [7:0]           r_ovr;
    logic                 r_rewait;
    logic [VEL_W-1:0]     r_lat_x;
    logic [VEL_W-1:0]     r_lat_y;
    logic [VEL_W-1:0]     r_snap_x [NUM_BOTS];
    logic [VEL_W-1:0]     r_snap_y [NUM_BOTS];

    logic [VEL_W-1:0]     w_in_x [NUM_BOTS];
    logic [VEL_W-1:0]     w_in_y [NUM_BOTS];
    logic [NUM_BOTS-1:0]  w_cand;
    logic [NUM_BOTS-1:0]  w_gnt;
    logic                 w_gnt_vld;
    logic [BW-1:0]        w_gnt_idx;
    logic [NUM_BOTS-1:0]  w_bot_oh;
    logic                 w_hs_y;
    logic                 w_in_send;
    logic                 w_rewait;
    logic                 w_cnt_tc;
    logic [3:0]           w_pend_cnt;
    logic [8:0]           w_ovr_sum;

`ifdef VEL_CLAMP_EN
    function automatic logic [VEL_W-1:0] sat_word(input logic [VEL_W-1:0] v);
        logic signed [31:0] w_ext;
        w_ext = 32'(signed'(v));
        return VEL_W'(vel_sat(w_ext, 32'(VEL_MAX)));
    endfunction
`endif

    for (genvar g = 0; g < NUM_BOTS; g++) begin : g_in
`ifdef VEL_CLAMP_EN
        assign w_in_x[g] = sat_word(vx_bin[g*VEL_W +: VEL_W]);
        assign w_in_y[g] = sat_word(vy_bin[g*VEL_W +: VEL_W]);
`else
        assign w_in_x[g] = vx_bin[g*VEL_W +: VEL_W];
        assign w_in_y[g] = vy_bin[g*VEL_W +: VEL_W];
`endif
    end

    assign w_cand = r_pend & bot_rdy;

    rr_arbiter #(
        .N (NUM_BOTS)
    ) u_arb (
        .i_req   (w_cand),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_valid (w_gnt_vld)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_BOTS; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = BW'(i);
            end
        end
    end

    always_comb begin
        w_pend_cnt = '0;
        for (int i = 0; i < NUM_BOTS; i++) begin
            w_pend_cnt = w_pend_cnt + {3'b000, r_pend[i]};
        end
    end

    assign w_bot_oh  = NUM_BOTS'(1) << r_bot;
    assign w_in_send = (r_state == ST_SEND_X) || (r_state == ST_SEND_Y);
    assign w_hs_y    = (r_state == ST_SEND_Y) && out_ready;
    assign w_rewait  = r_rewait || write_check;
    assign w_cnt_tc  = (r_cnt <= CW'(1));
    assign w_ovr_sum = {1'b0, r_ovr} + {5'b00000, w_pend_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bot   <= '0;
            r_ptr   <= BW'(NUM_BOTS - 1);
            r_lat_x <= '0;
            r_lat_y <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (write_check) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!write_check && w_cnt_tc) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (write_check) begin
                        r_state <= ST_WAIT;
                    end else if (r_pend == '0) begin
                        r_state <= ST_IDLE;
                    end else if (w_gnt_vld) begin
                        r_state <= ST_SEND_X;
                        r_bot   <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx;
                        r_lat_x <= r_snap_x[w_gnt_idx];
                        r_lat_y <= r_snap_y[w_gnt_idx];
                    end
                end
                ST_SEND_X: begin
                    if (out_ready) begin
                        r_state <= ST_SEND_Y;
                    end
                end
                ST_SEND_Y: begin
                    if (out_ready) begin
                        r_state <= w_rewait ? ST_WAIT : ST_ARB;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Counter reaches zero on the same edge that moves WAIT to ARB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (write_check || (w_hs_y && r_rewait)) begin
            r_cnt <= DLY_LOAD;
        end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rewait <= 1'b0;
        end else if (w_hs_y) begin
            r_rewait <= 1'b0;
        end else if (write_check && w_in_send) begin
            r_rewait <= 1'b1;
        end
    end

    // A new snapshot re-arms every bot, even the one whose transfer is finishing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (write_check) begin
            r_pend <= '1;
        end else if (w_hs_y) begin
            r_pend <= r_pend & ~w_bot_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
            r_ovr  <= '0;
        end else begin
            r_done <= w_hs_y ? w_bot_oh : '0;
            if (write_check) begin
                r_ovr <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
                r_snap_x[i] <= '0;
                r_snap_y[i] <= '0;
            end
        end else if (write_check) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
                r_snap_x[i] <= w_in_x[i];
                r_snap_y[i] <= w_in_y[i];
            end
        end
    end

    assign out_valid = w_in_send;
    assign out_sel   = (r_state == ST_SEND_Y) ? SEL_Y : SEL_X;
    assign out_data  = (r_state == ST_SEND_Y) ? r_lat_y : r_lat_x;
    assign out_bot   = r_bot;
    assign upd_done  = r_done;
    assign busy      = (r_state != ST_IDLE) || (r_pend != '0);
    assign ovr_cnt   = r_ovr;

endmodule

// File: tb/tb_vel_dispatch.sv
// Scoreboard bench for vel_dispatch: stimulus pushes expected beats and upd_done
// masks; a negedge monitor pops and compares whatever the DUT presents.
module tb_vel_dispatch;

    localparam int NB = 3;
    localparam int VW = 16;

    typedef struct {
        logic [1:0]  bot;
        logic        sel;
        logic [15:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_check;
    logic [NB*VW-1:0]  vx_bin;
    logic [NB*VW-1:0]  vy_bin;
    logic [NB-1:0]     bot_rdy;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_data;
    logic [1:0]        out_bot;
    logic              out_sel;
    logic [NB-1:0]     upd_done;
    logic              busy;
    logic [7:0]        ovr_cnt;

    int     n_checks = 0;
    int     n_fail   = 0;
    beat_t  exp_q[$];
    logic [2:0] done_q[$];
    beat_t  mon_e;
    logic [2:0] mon_d;
    int     n;

    vel_dispatch #(
        .NUM_BOTS     (NB),
        .VEL_W        (VW),
        .FRAC_W       (11),
        .DELAY_CYCLES (4),
        .VEL_MAX      (20480)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_check (write_check),
        .vx_bin      (vx_bin),
        .vy_bin      (vy_bin),
        .bot_rdy     (bot_rdy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_bot     (out_bot),
        .out_sel     (out_sel),
        .upd_done    (upd_done),
        .busy        (busy),
        .ovr_cnt     (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_bot(input logic [1:0] b, input logic [15:0] x, input logic [15:0] y);
        exp_q.push_back('{bot: b, sel: 1'b0, data: x});
        exp_q.push_back('{bot: b, sel: 1'b1, data: y});
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_wc(input logic [47:0] x, input logic [47:0] y);
        vx_bin      = x;
        vy_bin      = y;
        write_check = 1'b1;
        @(posedge clk);
        #1;
        write_check = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (out_valid) break;
            cnt++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 500) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && done_q.size() == 0) break;
            k++;
        end
        chk("idle_reached", 32'(k < 500), 32'd1);
    endtask

    // Monitor: every accepted beat and every upd_done pulse must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", {13'd0, out_bot, out_sel, out_data}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_bot",  32'(out_bot),  32'(mon_e.bot));
                    chk("beat_sel",  32'(out_sel),  32'(mon_e.sel));
                    chk("beat_data", 32'(out_data), 32'(mon_e.data));
                end
            end
            if (upd_done !== 3'b000 && upd_done !== 3'bxxx) begin
                if (done_q.size() == 0) begin
                    chk("upd_done_unexpected", 32'(upd_done), 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("upd_done", 32'(upd_done), 32'(mon_d));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        write_check = 1'b0;
        vx_bin      = '0;
        vy_bin      = '0;
        bot_rdy     = 3'b111;
        out_ready   = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_bot",   32'(out_bot),   32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_upd_done",  32'(upd_done),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_ovr_cnt",   32'(ovr_cnt),   32'd0);
        cyc(1);
        rst = 1'b0;

        // Basic burst: bots 0,1,2 in order, vx before vy.
        cyc(1);
        push_bot(2'd0, 16'h0800, 16'h0100);
        push_bot(2'd1, 16'h1000, 16'h0200);
        push_bot(2'd2, 16'h1800, 16'h0300);
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        done_q.push_back(3'b100);
        pulse_wc({16'h1800, 16'h1000, 16'h0800}, {16'h0300, 16'h0200, 16'h0100});
        chk("busy_in_wait", 32'(busy), 32'd1);
        wait_valid(n);
        chk("first_valid_latency", 32'(n), 32'd4);
        wait_idle();
        chk("burst_busy_low", 32'(busy), 32'd0);
        chk("burst_ovr", 32'(ovr_cnt), 32'd0);

        // Backpressure: outputs frozen while out_ready is low.
        cyc(1);
        out_ready = 1'b0;
        push_bot(2'd0, 16'h0AAA, 16'h0DDD);
        push_bot(2'd1, 16'h0BBB, 16'h0EEE);
        push_bot(2'd2, 16'h0CCC, 16'h0FFF);
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        done_q.push_back(3'b100);
        pulse_wc({16'h0CCC, 16'h0BBB, 16'h0AAA}, {16'h0FFF, 16'h0EEE, 16'h0DDD});
        wait_valid(n);
        chk("stall_valid_seen", 32'(n < 100), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h0AAA);
            chk("stall_bot",   32'(out_bot),   32'd0);
            chk("stall_sel",   32'(out_sel),   32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        chk("stall_ovr", 32'(ovr_cnt), 32'd0);

        // Bot 1 not ready; also a reload of the settle delay.
        cyc(1);
        bot_rdy = 3'b101;
        push_bot(2'd0, 16'h3456, 16'h6789);
        push_bot(2'd2, 16'h1234, 16'h4567);
        done_q.push_back(3'b001);
        done_q.push_back(3'b100);
        pulse_wc({16'h1234, 16'h2345, 16'h3456}, {16'h4567, 16'h5678, 16'h6789});
        cyc(1);
        pulse_wc({16'h1234, 16'h2345, 16'h3456}, {16'h4567, 16'h5678, 16'h6789});
        wait_valid(n);
        chk("reload_latency", 32'(n), 32'd4);
        n = 0;
        while (n < 200 && (exp_q.size() != 0 || done_q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_partial_done", 32'(n < 200), 32'd1);
        cyc(3);
        chk("busy_bot1_pending", 32'(busy), 32'd1);
        chk("arb_waits_no_valid", 32'(out_valid), 32'd0);
        chk("ovr_reload", 32'(ovr_cnt), 32'd3);
        push_bot(2'd1, 16'h2345, 16'h5678);
        done_q.push_back(3'b010);
        bot_rdy = 3'b111;
        wait_idle();
        chk("rdy_busy_low", 32'(busy), 32'd0);

        // Re-snapshot during bot 1 SEND_Y: old values finish, new ones follow.
        cyc(1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("ovr_after_rst", 32'(ovr_cnt), 32'd0);
        push_bot(2'd0, 16'h0A01, 16'h0B01);
        push_bot(2'd1, 16'h0A02, 16'h0B02);
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        pulse_wc({16'h0A03, 16'h0A02, 16'h0A01}, {16'h0B03, 16'h0B02, 16'h0B01});
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid && out_bot == 2'd1 && out_sel == 1'b1) break;
            n++;
        end
        chk("b1_sendy_seen", 32'(n < 100), 32'd1);
        vx_bin      = {16'h0C03, 16'h0C02, 16'h0C01};
        vy_bin      = {16'h0D03, 16'h0D02, 16'h0D01};
        write_check = 1'b1;
        push_bot(2'd2, 16'h0C03, 16'h0D03);
        push_bot(2'd0, 16'h0C01, 16'h0D01);
        push_bot(2'd1, 16'h0C02, 16'h0D02);
        done_q.push_back(3'b100);
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        @(posedge clk);
        #1;
        write_check = 1'b0;
        chk("ovr_two", 32'(ovr_cnt), 32'd2);
        wait_idle();
        chk("resend_ovr", 32'(ovr_cnt), 32'd2);

        // Clamp behaviour depends on the build.
        cyc(1);
        push_bot(2'd2, 16'h0000, 16'hF000);
`ifdef VEL_CLAMP_EN
        push_bot(2'd0, 16'h5000, 16'h0020);
        push_bot(2'd1, 16'hB000, 16'h0010);
`else
        push_bot(2'd0, 16'h7000, 16'h0020);
        push_bot(2'd1, 16'h9000, 16'h0010);
`endif
        done_q.push_back(3'b100);
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        pulse_wc({16'h0000, 16'h9000, 16'h7000}, {16'hF000, 16'h0010, 16'h0020});
        wait_idle();
        chk("clamp_ovr", 32'(ovr_cnt), 32'd2);

        // Reset in SEND_X aborts the transfer silently.
        cyc(1);
        out_ready = 1'b0;
        pulse_wc({16'h0111, 16'h0222, 16'h0333}, {16'h0444, 16'h0555, 16'h0666});
        wait_valid(n);
        chk("abort_valid_seen", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_upd_done",  32'(upd_done),  32'd0);
        chk("abort_ovr",       32'(ovr_cnt),   32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        cyc(4);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        chk("exp_q_drained",  32'(exp_q.size()),  32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
